ram_param: RTL and testbench
============================

# ram_param

Parametrised single-port synchronous RAM: the successor to the fixed 16-bit RAM16K storage block. Width and depth are configurable, and the read port is registered. A built-in clear engine sweeps every word to a fill value after reset or on request. It serves as the general data/program memory primitive behind the CPU's memory map.

## Interface
Parameters:
- WIDTH, 16, data word width in bits
- ADDR_W, 14, address width in bits
- DEPTH, 2**ADDR_W, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- FILL, 0, value written to every word by the clear engine

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  WIDTH  write data
- load  input  1  write enable, sampled at the rising edge
- address  input  ADDR_W  read/write address
- clear  input  1  single-cycle request to start a clear sweep
- busy  output  1  high while the clear sweep runs
- out  output  WIDTH  registered read data

## Operation
- Two states, CLEAR and IDLE.
- Reset asserted:
  - state=CLEAR, sweep counter=0, out=0, busy=1.
  - Array contents are not touched by reset itself.
- CLEAR state:
  - Each rising edge writes FILL to mem[counter], then counter increments.
  - When counter==DEPTH-1 is written, the next state is IDLE and the counter returns to 0.
  - load and address are ignored; out is held at 0.
  - clear is ignored; the sweep is not restarted.
- IDLE state:
  - If clear=1, the next state is CLEAR with counter=0. A write in that same cycle (load=1) is still performed first.
  - If load=1 and address<DEPTH, mem[address] is written with in.
  - If address>=DEPTH, the write is dropped and out loads 0.
  - Otherwise out loads mem[address] every edge (no read enable).
- busy equals (state==CLEAR) and is driven directly from the state register.
- Reset asserted mid-sweep or mid-write: the sweep restarts from word 0. A write in flight at the reset edge is discarded.

## Timing
- Write: takes effect at the rising edge where load=1 and busy=0.
- Read latency: 1 cycle. out after edge k reflects the address sampled at edge k.
- Clear sweep:
  - Occupies exactly DEPTH cycles.
  - After reset deassertion, busy stays high for DEPTH rising edges and falls after the DEPTH-th.
  - After a clear request, busy rises at the next edge and stays high for DEPTH edges.
- First usable cycle: the edge after busy falls. A read issued there returns FILL (or written data).
- Read-during-write to the same address: see Configuration.

## Configuration
- RAM_PARAM_WRITE_THROUGH_EN:
  - Defined: a same-cycle write and read to the same in-range address forwards the new data. out loads in.
  - Undefined (default): read-first. out loads the old mem[address]; new data is visible on the next read.
- The macro has no effect on clear-sweep or out-of-range behaviour.

## Test plan
- Reset sweep: ADDR_W=4, DEPTH=16, FILL=16'hA5A5; pulse reset -> busy=1 for exactly 16 edges after release, out=0 throughout; then reads of addresses 0..15 return 16'hA5A5.
- Write/read: write 16'h1000 to addr 1, 16'h2112 to addr 15 -> after 1-cycle latency, reads of 1 and 15 return 16'h1000 and 16'h2112; addr 2 returns FILL.
- Out of range: ADDR_W=4, DEPTH=10; write 16'h7777 to addr 12 -> read of 12 returns 0; addresses 0..9 are unchanged.
- Read-during-write: addr 3 holds 16'h0003; write 16'h0033 to addr 3 -> out=16'h0003 without the macro, 16'h0033 with RAM_PARAM_WRITE_THROUGH_EN; the following read returns 16'h0033 in both builds.
- Clear request: with data written, pulse clear together with load to addr 5 -> busy high for DEPTH cycles, load ignored during busy, all words read FILL afterwards; a second clear pulse mid-sweep does not extend busy.
- Reset mid-sweep: assert reset at sweep word 7 -> busy stays high and the sweep runs a full DEPTH cycles from word 0 after release.

Source files
------------

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read and clear sweep.
// Optional macro RAM_PARAM_WRITE_THROUGH_EN: same-address read-during-write forwards new data.
module ram_param #(
    parameter int               WIDTH  = 16,
    parameter int               ADDR_W = 14,
    parameter int               DEPTH  = 2**ADDR_W,
    parameter logic [WIDTH-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic              busy,
    output logic [WIDTH-1:0]  out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_rd;
    logic               w_we;
    logic [IDX_W-1:0]   w_waddr;
    logic [WIDTH-1:0]   w_wdata;

    assign w_in_range = ({1'b0, address} < DEPTH_X);
    assign w_idx      = address[IDX_W-1:0];
    assign w_rd       = r_mem[w_idx];
    assign busy       = (r_state == S_CLEAR);
    assign out        = r_out;

    // State and sweep counter; reset always restarts the sweep from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and the single write port: sweep writes FILL, idle writes user data.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_waddr     = '0;
        w_wdata     = '0;
        unique case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt[IDX_W-1:0];
                w_wdata = FILL;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (load && w_in_range) begin
                    w_we    = 1'b1;
                    w_waddr = w_idx;
                    w_wdata = in;
                end
                if (clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage array; a write coinciding with a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read: zero while sweeping or out of range, else array data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (r_state == S_CLEAR || !w_in_range) begin
            r_out <= '0;
        end else begin
`ifdef RAM_PARAM_WRITE_THROUGH_EN
            r_out <= load ? in : w_rd;
`else
            r_out <= w_rd;
`endif
        end
    end

endmodule

// File: tb/tb_ram_param.sv
// Directed self-checking bench for ram_param.
// Two instances share stimulus: DEPTH=16 (A) and DEPTH=10 (B).
module tb_ram_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [3:0]  address;
    logic        clear;
    logic        busy_a, busy_b;
    logic [15:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] FILL_A = 16'hA5A5;
    localparam logic [15:0] FILL_B = 16'h5A5A;

    always #5 clk = ~clk;

    ram_param #(
        .WIDTH(16), .ADDR_W(4), .DEPTH(16), .FILL(FILL_A)
    ) u_a (
        .clk(clk), .reset(reset), .in(in), .load(load),
        .address(address), .clear(clear), .busy(busy_a), .out(out_a)
    );

    ram_param #(
        .WIDTH(16), .ADDR_W(4), .DEPTH(10), .FILL(FILL_B)
    ) u_b (
        .clk(clk), .reset(reset), .in(in), .load(load),
        .address(address), .clear(clear), .busy(busy_b), .out(out_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rdw_exp;
        reset   = 1'b1;
        in      = '0;
        load    = 1'b0;
        address = '0;
        clear   = 1'b0;
        #1;
        chk("reset_busy_a", 16'(busy_a), 16'd1);
        chk("reset_out_a", out_a, 16'h0);
        step();
        step();
        chk("reset_hold_busy_b", 16'(busy_b), 16'd1);

        // Reset sweep: A busy for 16 edges, B for 10
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("sweep_busy_a", 16'(busy_a), (i < 15) ? 16'd1 : 16'd0);
            chk("sweep_busy_b", 16'(busy_b), (i < 9) ? 16'd1 : 16'd0);
            chk("sweep_out_a", out_a, 16'h0);
        end

        // Fill readback on both instances
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            step();
            chk("fill_a", out_a, FILL_A);
            chk("fill_b", out_b, (i < 10) ? FILL_B : 16'h0);
        end

        // Write / read
        load = 1'b1; address = 4'd1;  in = 16'h1000; step();
        address = 4'd15; in = 16'h2112; step();
        load = 1'b0; address = 4'd1; step();
        chk("wr_a1", out_a, 16'h1000);
        address = 4'd15; step();
        chk("wr_a15", out_a, 16'h2112);
        chk("oor_b15", out_b, 16'h0);
        address = 4'd2; step();
        chk("wr_a2_fill", out_a, FILL_A);

        // Out of range on B
        load = 1'b1; address = 4'd12; in = 16'h7777; step();
        load = 1'b0; step();
        chk("oor_b12", out_b, 16'h0);
        chk("inr_a12", out_a, 16'h7777);
        for (int i = 0; i < 10; i++) begin
            address = 4'(i);
            step();
            chk("oor_b_keep", out_b, (i == 1) ? 16'h1000 : FILL_B);
        end

        // Read during write
        load = 1'b1; address = 4'd3; in = 16'h0003; step();
        in = 16'h0033; step();
`ifdef RAM_PARAM_WRITE_THROUGH_EN
        rdw_exp = 16'h0033;
`else
        rdw_exp = 16'h0003;
`endif
        chk("rdw_a", out_a, rdw_exp);
        chk("rdw_b", out_b, rdw_exp);
        load = 1'b0; step();
        chk("rdw_next_a", out_a, 16'h0033);

        // Clear request with a coincident write
        clear = 1'b1; load = 1'b1; address = 4'd5; in = 16'h5555; step();
        chk("clr_busy_rise_a", 16'(busy_a), 16'd1);
        clear = 1'b0; address = 4'd6; in = 16'h6666;
        for (int j = 1; j <= 16; j++) begin
            clear = (j == 5);
            step();
            chk("clr_busy_a", 16'(busy_a), (j < 16) ? 16'd1 : 16'd0);
            chk("clr_busy_b", 16'(busy_b), (j < 10) ? 16'd1 : 16'd0);
            if (j < 16) chk("clr_out_a", out_a, 16'h0);
        end
        clear = 1'b0; load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            step();
            chk("clr_fill_a", out_a, FILL_A);
        end

        // Reset mid-sweep
        load = 1'b1; address = 4'd0; in = 16'hBEEF; step();
        load = 1'b0;
        clear = 1'b1; step();
        clear = 1'b0;
        for (int j = 0; j < 7; j++) step();
        chk("mid_busy_pre", 16'(busy_a), 16'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy_a", 16'(busy_a), 16'd1);
        chk("mid_rst_out_a", out_a, 16'h0);
        step();
        reset = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            chk("mid_busy_a", 16'(busy_a), (j < 16) ? 16'd1 : 16'd0);
            chk("mid_busy_b", 16'(busy_b), (j < 10) ? 16'd1 : 16'd0);
        end
        address = 4'd0; step();
        chk("mid_fill_a0", out_a, FILL_A);
        address = 4'd15; step();
        chk("mid_fill_a15", out_a, FILL_A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
